// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a small circular byte FIFO.
// ovf and ferr are sticky error flags, cleared by clr_err or by reset.
module uart_rx_fifo #(
   parameter int BIT_CLKS = 217,
   parameter int DEPTH    = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rxd,
   input  logic       rd,
   input  logic       clr_err,
   output logic [7:0] dout,
   output logic       dv,
   output logic       ovf,
   output logic       ferr
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL      = CW'(DEPTH);
   localparam logic [15:0]   HALF_LAST = 16'(BIT_CLKS / 2 - 1);
   localparam logic [15:0]   BIT_LAST  = 16'(BIT_CLKS - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [1:0] sync_reg, sync_in;
   logic       rs, rs_d_reg;
   logic [2:0] live_reg;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            assign sync_in[gi] = rxd;
         end else begin : g_rest
            assign sync_in[gi] = sync_reg[gi-1];
         end
      end
   endgenerate

   assign rs = sync_reg[1];

   // live_reg fills once the synchronizer holds real line samples; until then
   // the forced-high reset values would fake a falling edge on a low line.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_reg <= 2'b11;
         rs_d_reg <= 1'b1;
         live_reg <= 3'b000;
      end else begin
         sync_reg <= sync_in;
         rs_d_reg <= rs;
         live_reg <= {live_reg[1:0], 1'b1};
      end
   end

   state_t      state_reg, state_next;
   logic [15:0] cnt_reg, cnt_next;
   logic [2:0]  idx_reg, idx_next;
   logic [7:0]  shift_reg, shift_next;
   logic        push, ferr_set;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         cnt_reg   <= 16'd0;
         idx_reg   <= 3'd0;
         shift_reg <= 8'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         idx_reg   <= idx_next;
         shift_reg <= shift_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg + 16'd1;
      idx_next   = idx_reg;
      shift_next = shift_reg;
      push       = 1'b0;
      ferr_set   = 1'b0;
      case (state_reg)
         IDLE: begin
            cnt_next = 16'd0;
            if (live_reg[2] && rs_d_reg && !rs) state_next = START;
         end
         START: begin
            if (cnt_reg == HALF_LAST) begin
               cnt_next = 16'd0;
               if (rs) begin
                  state_next = IDLE;
               end else begin
                  state_next = DATA;
                  idx_next   = 3'd0;
               end
            end
         end
         DATA: begin
            if (cnt_reg == BIT_LAST) begin
               cnt_next            = 16'd0;
               shift_next[idx_reg] = rs;
               if (idx_reg == 3'd7) state_next = STOP;
               else                 idx_next   = idx_reg + 3'd1;
            end
         end
         STOP: begin
            if (cnt_reg == BIT_LAST) begin
               cnt_next   = 16'd0;
               state_next = IDLE;
               push       = rs;
               ferr_set   = !rs;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] rd_ptr_reg, wr_ptr_reg;
   logic [CW-1:0] count_reg;
   logic          ovf_reg, ferr_reg;
   logic          pop, do_push, ovf_set;

   // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
   assign pop     = rd && (count_reg != '0);
   assign do_push = push && ((count_reg != FULL) || pop);
   assign ovf_set = push && (count_reg == FULL) && !pop;

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
         ovf_reg    <= 1'b0;
         ferr_reg   <= 1'b0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_reg + CW'(do_push) - CW'(pop);
         ovf_reg   <= ovf_set  | (ovf_reg  & ~clr_err);
         ferr_reg  <= ferr_set | (ferr_reg & ~clr_err);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !reset) mem[wr_ptr_reg] <= shift_reg;
   end

   assign dout = mem[rd_ptr_reg];
   assign dv   = (count_reg != '0);
   assign ovf  = ovf_reg;
   assign ferr = ferr_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: serial frames are driven on rxd, the
// expected bytes are queued, and each pop is compared against the queue head.
module tb_uart_rx_fifo;

   localparam int B         = 217;
   localparam int H         = B / 2;
   localparam int DEPTH     = 4;
   localparam int PUSH_EDGE = 3 + H + 9 * B;
   localparam int SPEC_LAT  = 2 + 1 + H + 9 * B + 1;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rxd = 1'b1;
   logic       rd = 1'b0;
   logic       clr_err = 1'b0;
   logic [7:0] dout;
   logic       dv, ovf, ferr;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   int         seen_edge;

   uart_rx_fifo #(.BIT_CLKS(B), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .rxd(rxd), .rd(rd), .clr_err(clr_err),
      .dout(dout), .dv(dv), .ovf(ovf), .ferr(ferr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic line(input int n, input logic lvl);
      repeat (n) begin
         @(negedge clk);
         rxd = lvl;
      end
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
   endtask

   // Drives one frame; optionally asserts rd for exactly the push cycle.
   task automatic send_byte(input logic [7:0] b, input logic stop, input bit pop_at_push);
      logic [9:0] frame;
      bit         track;
      int         edge_no;
      frame     = {stop, b, 1'b0};
      track     = (exp_q.size() == 0) && !pop_at_push;
      seen_edge = -1;
      for (int j = 0; j < 10; j++) begin
         for (int c = 0; c < B; c++) begin
            @(negedge clk);
            edge_no = j * B + c + 1;
            if (track && seen_edge < 0 && dv === 1'b1) seen_edge = edge_no - 1;
            rxd = frame[j];
            if (pop_at_push && edge_no == PUSH_EDGE) begin
               rd = 1'b1;
               check("same_cycle_pop_head", dout, exp_q.pop_front());
            end else begin
               rd = 1'b0;
            end
         end
      end
      rd = 1'b0;
      if (stop) begin
         if (exp_q.size() < DEPTH) exp_q.push_back(b);
      end
   endtask

   task automatic pop_check(input string tag);
      logic [7:0] e;
      @(negedge clk);
      e = exp_q.pop_front();
      check({tag, "_dv"}, dv, 1);
      check({tag, "_dout"}, dout, e);
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
   endtask

   task automatic drain(input string tag);
      while (exp_q.size() > 0) pop_check(tag);
      @(negedge clk);
      check({tag, "_empty"}, dv, 0);
   endtask

   initial begin
      repeat (5) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset_dv", dv, 0);
      check("reset_ovf", ovf, 0);
      check("reset_ferr", ferr, 0);
      line(20, 1'b1);

      // Single byte with latency measurement
      send_byte(8'h55, 1'b1, 0);
      $display("info latency edges=%0d window=%0d..%0d", seen_edge, SPEC_LAT - 1, SPEC_LAT + 1);
      check("latency_in_window", (seen_edge >= SPEC_LAT - 1) && (seen_edge <= SPEC_LAT + 1), 1);
      check("b55_ovf", ovf, 0);
      check("b55_ferr", ferr, 0);
      drain("b55");

      // Back-to-back fill, ordered readback
      send_byte(8'hA3, 1'b1, 0);
      send_byte(8'h00, 1'b1, 0);
      send_byte(8'hFF, 1'b1, 0);
      send_byte(8'h81, 1'b1, 0);
      check("fill4_ovf", ovf, 0);
      drain("fill4");

      // Overflow: fifth byte dropped
      send_byte(8'h11, 1'b1, 0);
      send_byte(8'h22, 1'b1, 0);
      send_byte(8'h33, 1'b1, 0);
      send_byte(8'h44, 1'b1, 0);
      send_byte(8'h55, 1'b1, 0);
      check("ovf_set", ovf, 1);
      pulse_clr();
      check("ovf_cleared", ovf, 0);

      // Full FIFO with a pop in the push cycle
      send_byte(8'h66, 1'b1, 1);
      check("full_pushpop_ovf", ovf, 0);
      drain("full_pushpop");

      // Framing error, line held low, then a clean byte
      send_byte(8'h99, 1'b0, 0);
      line(3 * B, 1'b0);
      line(20, 1'b1);
      check("ferr_set", ferr, 1);
      check("ferr_nopush", dv, 0);
      send_byte(8'h3C, 1'b1, 0);
      drain("after_ferr");
      pulse_clr();
      check("ferr_cleared", ferr, 0);

      // Start-bit glitch
      line(50, 1'b0);
      line(2 * B, 1'b1);
      check("glitch_dv", dv, 0);
      check("glitch_ferr", ferr, 0);
      send_byte(8'h7E, 1'b1, 0);
      drain("after_glitch");

      // Reset mid-DATA with the line still low afterwards
      line(4 * B, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      line(100, 1'b0);
      line(2 * B, 1'b1);
      check("midreset_dv", dv, 0);
      check("midreset_ferr", ferr, 0);
      check("midreset_ovf", ovf, 0);
      send_byte(8'h5A, 1'b1, 0);
      drain("after_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
